// File: rtl/half_ser_pkg.sv
// Shared types and defaults for the half-word serializer.
package half_ser_pkg;

  // Serializer FSM states.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_FIRST  = 2'd1,
    SEND_SECOND = 2'd2
  } ser_state_t;

  // Default word width.
  localparam int unsigned SER_DEFAULT_N = 32'd16;

endpackage : half_ser_pkg

// File: rtl/half_word_serializer.sv
// Half-word serializer: takes an N-bit word plus per-half send flags and
// emits the selected halves, one per cycle, over an N/2-bit valid/ready
// stream. A new word may be taken in the same cycle as the final half of
// the previous word transfers, so consecutive words run without a bubble.
module half_word_serializer
  import half_ser_pkg::*;
#(
  parameter int unsigned N        = SER_DEFAULT_N,
  parameter bit          HI_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-32'd1:0]        in_data,
  input  logic                    in_sendh,
  input  logic                    in_sendl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(N/32'd2)-32'd1:0] out_data,
  output logic                    out_is_hi,
  output logic                    out_last
);

  localparam int unsigned H = N / 32'd2;

  // Reject widths that cannot be split into two equal halves.
  generate
    if (((N % 32'd2) != 32'd0) || (N < 32'd2)) begin : g_bad_width
      $error("half_word_serializer: N must be even and >= 2");
    end
  endgenerate

  // State and held word.
  ser_state_t         r_state;
  ser_state_t         w_state_next;
  logic [N-32'd1:0]   r_word;
  logic               r_sendh;
  logic               r_sendl;

  // Registered output stream.
  logic               r_out_valid;
  logic [H-32'd1:0]   r_out_data;
  logic               r_out_is_hi;
  logic               r_out_last;

  // Handshake decode.
  logic               w_accept;
  logic               w_xfer;
  logic               w_in_ready;
  logic               w_has_second;

  // First half selected from an incoming word.
  ser_state_t         w_acc_state;
  logic               w_acc_valid;
  logic [H-32'd1:0]   w_acc_data;
  logic               w_acc_is_hi;
  logic               w_acc_last;

  // Next values of the output register.
  logic               w_valid_next;
  logic [H-32'd1:0]   w_data_next;
  logic               w_is_hi_next;
  logic               w_last_next;

  assign w_in_ready   = (r_state == IDLE) || (r_out_valid && r_out_last && out_ready);
  assign w_accept     = in_valid && w_in_ready;
  assign w_xfer       = r_out_valid && out_ready;
  assign w_has_second = r_sendh && r_sendl;

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_is_hi = r_out_is_hi;
  assign out_last  = r_out_last;

  // Decode which half of an incoming word goes out first, and whether it is the last.
  always_comb begin
    w_acc_valid = in_sendh | in_sendl;
    w_acc_state = (in_sendh | in_sendl) ? SEND_FIRST : IDLE;
    w_acc_last  = 1'b1;
    w_acc_is_hi = 1'b0;
    w_acc_data  = in_data[H-32'd1:0];
    if (in_sendh && in_sendl) begin
      w_acc_last  = 1'b0;
      w_acc_is_hi = HI_FIRST;
      w_acc_data  = HI_FIRST ? in_data[N-32'd1:H] : in_data[H-32'd1:0];
    end else if (in_sendh) begin
      w_acc_is_hi = 1'b1;
      w_acc_data  = in_data[N-32'd1:H];
    end else begin
      w_acc_is_hi = 1'b0;
      w_acc_data  = in_data[H-32'd1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: advance on half transfers, chain straight into a new word when one is accepted.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_acc_state;
        end else begin
          w_state_next = IDLE;
        end
      end
      SEND_FIRST: begin
        if (!w_xfer) begin
          w_state_next = SEND_FIRST;
        end else if (w_has_second) begin
          w_state_next = SEND_SECOND;
        end else if (w_accept) begin
          w_state_next = w_acc_state;
        end else begin
          w_state_next = IDLE;
        end
      end
      SEND_SECOND: begin
        if (!w_xfer) begin
          w_state_next = SEND_SECOND;
        end else if (w_accept) begin
          w_state_next = w_acc_state;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Output decode: load a new first half, step to the second half, retire, or hold stable.
  always_comb begin
    w_valid_next = r_out_valid;
    w_data_next  = r_out_data;
    w_is_hi_next = r_out_is_hi;
    w_last_next  = r_out_last;
    if (w_accept) begin
      w_valid_next = w_acc_valid;
      w_data_next  = w_acc_data;
      w_is_hi_next = w_acc_is_hi;
      w_last_next  = w_acc_last;
    end else if (w_xfer && (r_state == SEND_FIRST) && w_has_second) begin
      w_valid_next = 1'b1;
      w_data_next  = r_out_is_hi ? r_word[H-32'd1:0] : r_word[N-32'd1:H];
      w_is_hi_next = ~r_out_is_hi;
      w_last_next  = 1'b1;
    end else if (w_xfer) begin
      w_valid_next = 1'b0;
    end else begin
      w_valid_next = r_out_valid;
    end
  end

  // Output register and held word/flags; the word is captured only on accept.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_word      <= '0;
      r_sendh     <= 1'b0;
      r_sendl     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_is_hi <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word  <= in_data;
        r_sendh <= in_sendh;
        r_sendl <= in_sendl;
      end
      r_out_valid <= w_valid_next;
      r_out_data  <= w_data_next;
      r_out_is_hi <= w_is_hi_next;
      r_out_last  <= w_last_next;
    end
  end

endmodule : half_word_serializer

// File: tb/tb_half_word_serializer.sv
// Directed scoreboard bench for half_word_serializer (N=16), with a second
// instance configured low-half-first.
module tb_half_word_serializer;

  logic        clk;
  logic        clear_n;

  logic        in_valid, in_ready, in_sendh, in_sendl;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_is_hi, out_last;
  logic [7:0]  out_data;

  logic        b_in_valid, b_in_ready, b_in_sendh, b_in_sendl;
  logic [15:0] b_in_data;
  logic        b_out_valid, b_out_ready, b_out_is_hi, b_out_last;
  logic [7:0]  b_out_data;

  int checks = 0;
  int errors = 0;
  logic [9:0] q[$];

  half_word_serializer #(.N(16), .HI_FIRST(1'b1)) u_dut (
    .clk(clk), .clear_n(clear_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sendh(in_sendh), .in_sendl(in_sendl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_hi(out_is_hi), .out_last(out_last)
  );

  half_word_serializer #(.N(16), .HI_FIRST(1'b0)) u_lofirst (
    .clk(clk), .clear_n(clear_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sendh(b_in_sendh), .in_sendl(b_in_sendl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_is_hi(b_out_is_hi), .out_last(b_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] exp_half(input logic [7:0] d, input logic hi, input logic last);
    return {d, hi, last};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare a presented half against the head of the scoreboard.
  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic hi, input logic last);
    logic [9:0] e;
    chk_eq({tag, ".valid"}, {31'd0, v}, 32'd1);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed output with empty scoreboard, expected none", tag);
    end else begin
      e = q.pop_front();
      chk_eq({tag, ".half"}, {22'd0, d, hi, last}, {22'd0, e});
    end
  endtask

  initial begin
    clear_n   = 1'b0;
    in_valid  = 1'b0; in_data = 16'h0000; in_sendh = 1'b0; in_sendl = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 16'h0000; b_in_sendh = 1'b0; b_in_sendl = 1'b0; b_out_ready = 1'b0;

    // Reset state
    tick();
    chk_eq("rst.valid", {31'd0, out_valid}, 32'd0);
    chk_eq("rst.data",  {24'd0, out_data},  32'd0);
    chk_eq("rst.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    clear_n = 1'b1;
    tick();

    // Test 2: single word, both halves, high first
    in_valid = 1'b1; in_data = 16'hA55A; in_sendh = 1'b1; in_sendl = 1'b1; out_ready = 1'b1;
    chk_eq("t2.in_ready_idle", {31'd0, in_ready}, 32'd1);
    q.push_back(exp_half(8'hA5, 1'b1, 1'b0));
    q.push_back(exp_half(8'h5A, 1'b0, 1'b1));
    tick();
    in_valid = 1'b0;
    chk_out("t2.h0", out_valid, out_data, out_is_hi, out_last);
    tick();
    chk_out("t2.h1", out_valid, out_data, out_is_hi, out_last);
    chk_eq("t2.in_ready_last", {31'd0, in_ready}, 32'd1);
    tick();
    chk_eq("t2.idle_valid", {31'd0, out_valid}, 32'd0);

    // Test 3: back-to-back words without a bubble
    in_valid = 1'b1; in_data = 16'h1234; in_sendh = 1'b1; in_sendl = 1'b1;
    q.push_back(exp_half(8'h12, 1'b1, 1'b0));
    q.push_back(exp_half(8'h34, 1'b0, 1'b1));
    tick();
    in_data = 16'hBEEF;
    chk_out("t3.c1", out_valid, out_data, out_is_hi, out_last);
    chk_eq("t3.in_ready_c1", {31'd0, in_ready}, 32'd0);
    tick();
    q.push_back(exp_half(8'hBE, 1'b1, 1'b0));
    q.push_back(exp_half(8'hEF, 1'b0, 1'b1));
    chk_out("t3.c2", out_valid, out_data, out_is_hi, out_last);
    chk_eq("t3.in_ready_c2", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("t3.c3", out_valid, out_data, out_is_hi, out_last);
    chk_eq("t3.in_ready_c3", {31'd0, in_ready}, 32'd0);
    tick();
    chk_out("t3.c4", out_valid, out_data, out_is_hi, out_last);
    chk_eq("t3.in_ready_c4", {31'd0, in_ready}, 32'd1);
    tick();
    chk_eq("t3.idle_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("t3.queue_empty", q.size(), 32'd0);

    // Test 4: downstream stall holds the first half
    in_valid = 1'b1; in_data = 16'hA55A; in_sendh = 1'b1; in_sendl = 1'b1; out_ready = 1'b0;
    q.push_back(exp_half(8'hA5, 1'b1, 1'b0));
    q.push_back(exp_half(8'h5A, 1'b0, 1'b1));
    tick();
    in_valid = 1'b0; in_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      chk_eq("t4.stall_valid", {31'd0, out_valid}, 32'd1);
      chk_eq("t4.stall_data", {24'd0, out_data}, 32'h0000_00A5);
      chk_eq("t4.stall_flags", {30'd0, out_is_hi, out_last}, 32'd2);
      chk_eq("t4.stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    chk_out("t4.h0", out_valid, out_data, out_is_hi, out_last);
    tick();
    chk_out("t4.h1", out_valid, out_data, out_is_hi, out_last);
    tick();
    chk_eq("t4.idle_valid", {31'd0, out_valid}, 32'd0);

    // Test 5: single-half flags and a word with no halves selected
    in_valid = 1'b1; in_data = 16'hC3D4; in_sendh = 1'b0; in_sendl = 1'b1;
    q.push_back(exp_half(8'hD4, 1'b0, 1'b1));
    tick();
    in_data = 16'h7788; in_sendh = 1'b1; in_sendl = 1'b0;
    chk_out("t5.lo_only", out_valid, out_data, out_is_hi, out_last);
    chk_eq("t5.in_ready_lo", {31'd0, in_ready}, 32'd1);
    q.push_back(exp_half(8'h77, 1'b1, 1'b1));
    tick();
    in_valid = 1'b0;
    chk_out("t5.hi_only", out_valid, out_data, out_is_hi, out_last);
    tick();
    chk_eq("t5.idle_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_data = 16'h9999; in_sendh = 1'b0; in_sendl = 1'b0;
    chk_eq("t5.in_ready_none", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk_eq("t5.none_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("t5.none_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_eq("t5.none_valid2", {31'd0, out_valid}, 32'd0);

    // Test 1: asynchronous reset in the middle of the second half
    in_valid = 1'b1; in_data = 16'hA55A; in_sendh = 1'b1; in_sendl = 1'b1; out_ready = 1'b1;
    q.push_back(exp_half(8'hA5, 1'b1, 1'b0));
    q.push_back(exp_half(8'h5A, 1'b0, 1'b1));
    tick();
    in_valid = 1'b0;
    chk_out("t1.h0", out_valid, out_data, out_is_hi, out_last);
    tick();
    out_ready = 1'b0;
    chk_eq("t1.second_shown", {24'd0, out_data}, 32'h0000_005A);
    #3;
    clear_n = 1'b0;
    #1;
    chk_eq("t1.rst_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("t1.rst_data", {24'd0, out_data}, 32'd0);
    chk_eq("t1.rst_flags", {30'd0, out_is_hi, out_last}, 32'd0);
    q.delete();
    #2;
    clear_n = 1'b1;
    tick();
    chk_eq("t1.in_ready_after", {31'd0, in_ready}, 32'd1);
    chk_eq("t1.valid_after", {31'd0, out_valid}, 32'd0);

    // Test 6: low-half-first instance
    b_in_valid = 1'b1; b_in_data = 16'hA55A; b_in_sendh = 1'b1; b_in_sendl = 1'b1; b_out_ready = 1'b1;
    q.push_back(exp_half(8'h5A, 1'b0, 1'b0));
    q.push_back(exp_half(8'hA5, 1'b1, 1'b1));
    tick();
    b_in_valid = 1'b0;
    chk_out("t6.h0", b_out_valid, b_out_data, b_out_is_hi, b_out_last);
    tick();
    chk_out("t6.h1", b_out_valid, b_out_data, b_out_is_hi, b_out_last);
    tick();
    chk_eq("t6.idle_valid", {31'd0, b_out_valid}, 32'd0);
    chk_eq("t6.queue_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_half_word_serializer
